// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative, write-back, write-allocate L1 data cache.
// The CPU side is a single-word load/store port with a stall output. The memory
// side is a full-line port with an enable/write/ack handshake. Replacement is
// true LRU, using a per-way age where 0 means most recently used.
// Optional feature macro: DCACHE_PERF_CNT_EN adds hit/miss/write-back counters.
module dcache_assoc #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned WAYS       = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         p1_addr_i,
  input  logic [ADDR_W-1:0]         p1_data_i,
  input  logic                      p1_MemRead_i,
  input  logic                      p1_MemWrite_i,
  output logic [ADDR_W-1:0]         p1_data_o,
  output logic                      p1_stall_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [8*LINE_BYTES-1:0]   mem_data_o,
  input  logic [8*LINE_BYTES-1:0]   mem_data_i,
  output logic                      mem_enable_o,
  output logic                      mem_write_o,
  input  logic                      mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]               perf_hit_o,
  output logic [31:0]               perf_miss_o,
  output logic [31:0]               perf_wb_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LRU_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned WORDS  = (8 * LINE_BYTES) / ADDR_W;
  localparam int unsigned WORD_W = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILLDONE} state_e;
  typedef logic [WORDS-1:0][ADDR_W-1:0] line_t;

  // Storage: valid/dirty/age are reset, tag/line are plain arrays.
  logic              valid_mem [SETS][WAYS];
  logic              dirty_mem [SETS][WAYS];
  logic [LRU_W-1:0]  age_mem   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  line_t             line_mem  [SETS][WAYS];

  state_e            state, state_n;
  logic              en_q, en_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LRU_W-1:0]  vic_q;
  logic              miss_start;
  logic              refill_done;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req;
  logic              hit;
  logic              hit_ok;
  logic [LRU_W-1:0]  hit_way;
  logic [LRU_W-1:0]  hit_age;
  logic [LRU_W-1:0]  victim;
  logic              vic_found;
  logic              vic_dirty;
  logic              unused_addr;

  assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
  assign req_word    = p1_addr_i[2 +: WORD_W];
  assign unused_addr = ^p1_addr_i[1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_mem[req_idx][LRU_W'(w)] && (tag_mem[req_idx][LRU_W'(w)] == req_tag)) begin
        hit     = 1'b1;
        hit_way = LRU_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    vic_found = 1'b0;
    victim    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_mem[req_idx][LRU_W'(w)]) begin
        victim    = LRU_W'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_mem[req_idx][LRU_W'(w)] == LRU_W'(WAYS - 1)) begin
          victim = LRU_W'(w);
        end
      end
    end
  end

  // Hits are only honoured while the arrays are not being replaced.
  assign hit_ok     = hit && ((state == IDLE) || (state == FILLDONE));
  assign hit_age    = age_mem[req_idx][hit_way];
  assign vic_dirty  = valid_mem[req_idx][victim] && dirty_mem[req_idx][victim];
  assign p1_stall_o = req && !hit_ok;
  assign p1_data_o  = (p1_MemRead_i && hit_ok) ? line_mem[req_idx][hit_way][req_word] : '0;

  assign mem_enable_o = en_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  // Victim line is stable in the arrays for the whole write-back.
  assign mem_data_o   = line_mem[idx_q][vic_q];

  // Next-state and next memory-request values.
  always_comb begin
    state_n     = state;
    en_n        = en_q;
    wr_n        = wr_q;
    addr_n      = addr_q;
    miss_start  = 1'b0;
    refill_done = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          miss_start = 1'b1;
          en_n       = 1'b1;
          if (vic_dirty) begin
            state_n = WRITEBACK;
            wr_n    = 1'b1;
            addr_n  = {tag_mem[req_idx][victim], req_idx, {OFF_W{1'b0}}};
          end else begin
            state_n = REFILL;
            wr_n    = 1'b0;
            addr_n  = {req_tag, req_idx, {OFF_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_n = REFILL;
          wr_n    = 1'b0;
          addr_n  = {tag_q, idx_q, {OFF_W{1'b0}}};
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          state_n     = FILLDONE;
          en_n        = 1'b0;
          wr_n        = 1'b0;
          refill_done = 1'b1;
        end
      end
      FILLDONE: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // FSM state, registered memory request and latched miss context.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      en_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      tag_q  <= '0;
      idx_q  <= '0;
      vic_q  <= '0;
    end else begin
      state  <= state_n;
      en_q   <= en_n;
      wr_q   <= wr_n;
      addr_q <= addr_n;
      if (miss_start) begin
        tag_q <= req_tag;
        idx_q <= req_idx;
        vic_q <= victim;
      end
    end
  end

  // Valid, dirty and LRU age bookkeeping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_mem[IDX_W'(s)][LRU_W'(w)] <= 1'b0;
          dirty_mem[IDX_W'(s)][LRU_W'(w)] <= 1'b0;
          age_mem[IDX_W'(s)][LRU_W'(w)]   <= LRU_W'(w);
        end
      end
    end else begin
      if (refill_done) begin
        valid_mem[idx_q][vic_q] <= 1'b1;
        dirty_mem[idx_q][vic_q] <= 1'b0;
      end
      if (req && hit_ok) begin
        if (p1_MemWrite_i) begin
          dirty_mem[req_idx][hit_way] <= 1'b1;
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (LRU_W'(w) == hit_way) begin
            age_mem[req_idx][LRU_W'(w)] <= '0;
          end else if (age_mem[req_idx][LRU_W'(w)] < hit_age) begin
            age_mem[req_idx][LRU_W'(w)] <= age_mem[req_idx][LRU_W'(w)] + 1'b1;
          end
        end
      end
    end
  end

  // Tag and line data: refill install and store-hit word update.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      tag_mem[idx_q][vic_q]  <= tag_q;
      line_mem[idx_q][vic_q] <= mem_data_i;
    end
    if (p1_MemWrite_i && hit_ok) begin
      line_mem[req_idx][hit_way][req_word] <= p1_data_i;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
      perf_wb_o   <= '0;
    end else begin
      if ((state == IDLE) && req && hit) perf_hit_o <= perf_hit_o + 32'd1;
      if (miss_start) perf_miss_o <= perf_miss_o + 32'd1;
      if ((state == WRITEBACK) && mem_ack_i) perf_wb_o <= perf_wb_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Testbench for dcache_assoc: default 2-way geometry plus a direct-mapped build.
module tb_dcache_assoc;

  localparam logic [1:0] LD = 2'd1;
  localparam logic [1:0] ST = 2'd2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  p_addr, p_wdata, p_rdata;
  logic         p_rd, p_wr, p_stall;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata, m_rdata;
  logic         m_en, m_wr, m_ack;

  logic [31:0]  d_addr, d_wdata, d_rdata;
  logic         d_rd, d_wr, d_stall;
  logic [31:0]  dm_addr;
  logic [255:0] dm_wdata, dm_rdata;
  logic         dm_en, dm_wr, dm_ack;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  perf_hit, perf_miss, perf_wb;
  logic [31:0]  dperf_hit, dperf_miss, dperf_wb;
`endif

  int           tests = 0;
  int           fails = 0;
  int           lat = 1;
  int           poke_req = 0;
  int           dm_nwr = 0;
  int           dm_nrd = 0;
  bit           log_wr[$];
  logic [31:0]  log_addr[$];
  logic [255:0] mem_store [logic [31:0]];

  always #5 clk = ~clk;

  dcache_assoc #(.ADDR_W(32), .LINE_BYTES(32), .SETS(16), .WAYS(2)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .p1_addr_i(p_addr), .p1_data_i(p_wdata),
    .p1_MemRead_i(p_rd), .p1_MemWrite_i(p_wr),
    .p1_data_o(p_rdata), .p1_stall_o(p_stall),
    .mem_addr_o(m_addr), .mem_data_o(m_wdata), .mem_data_i(m_rdata),
    .mem_enable_o(m_en), .mem_write_o(m_wr), .mem_ack_i(m_ack)
`ifdef DCACHE_PERF_CNT_EN
    , .perf_hit_o(perf_hit), .perf_miss_o(perf_miss), .perf_wb_o(perf_wb)
`endif
  );

  dcache_assoc #(.ADDR_W(32), .LINE_BYTES(32), .SETS(32), .WAYS(1)) u_dm (
    .clk_i(clk), .rst_i(rst_n),
    .p1_addr_i(d_addr), .p1_data_i(d_wdata),
    .p1_MemRead_i(d_rd), .p1_MemWrite_i(d_wr),
    .p1_data_o(d_rdata), .p1_stall_o(d_stall),
    .mem_addr_o(dm_addr), .mem_data_o(dm_wdata), .mem_data_i(dm_rdata),
    .mem_enable_o(dm_en), .mem_write_o(dm_wr), .mem_ack_i(dm_ack)
`ifdef DCACHE_PERF_CNT_EN
    , .perf_hit_o(dperf_hit), .perf_miss_o(dperf_miss), .perf_wb_o(dperf_wb)
`endif
  );

  function automatic logic [255:0] pat_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    if (mem_store.exists(la)) return mem_store[la];
    return pat_line(la);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory model for the main DUT: programmable latency, logs every transaction.
  initial begin
    int cnt;
    int poke_seen;
    logic [255:0] tmp;
    cnt = 0;
    poke_seen = 0;
    m_ack = 1'b0;
    m_rdata = '0;
    tmp = pat_line(32'h40);
    tmp[63:32] = 32'hDEAD_BEEF;
    mem_store[32'h40] = tmp;
    forever begin
      @(negedge clk);
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (poke_req != poke_seen) begin
        poke_seen = poke_req;
        m_ack = 1'b1;
      end else if (!rst_n || !m_en) begin
        cnt = 0;
      end else if (cnt == lat) begin
        cnt = 0;
        log_wr.push_back(m_wr);
        log_addr.push_back(m_addr);
        if (m_wr) mem_store[m_addr] = m_wdata;
        else m_rdata = get_line(m_addr);
        m_ack = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  // Memory model for the direct-mapped DUT: fixed pattern, zero extra latency.
  initial begin
    dm_ack = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (dm_ack) dm_ack = 1'b0;
      else if (rst_n && dm_en) begin
        if (dm_wr) dm_nwr++;
        else begin
          dm_nrd++;
          dm_rdata = pat_line(dm_addr);
        end
        dm_ack = 1'b1;
      end
    end
  end

  // Entered just after a negedge; returns just after a later negedge.
  task automatic do_access(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                           output bit missed, output logic [31:0] rd, output bit tmo);
    p_addr = a; p_wdata = wd; p_rd = (cmd == LD); p_wr = (cmd == ST);
    #1;
    missed = p_stall;
    for (int i = 0; i < 300 && p_stall; i++) begin
      @(negedge clk); #1;
    end
    tmo = p_stall;
    rd = p_rdata;
    @(negedge clk);
    p_rd = 1'b0; p_wr = 1'b0;
  endtask

  task automatic dm_access(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                           output bit missed, output logic [31:0] rd, output bit tmo);
    d_addr = a; d_wdata = wd; d_rd = (cmd == LD); d_wr = (cmd == ST);
    #1;
    missed = d_stall;
    for (int i = 0; i < 300 && d_stall; i++) begin
      @(negedge clk); #1;
    end
    tmo = d_stall;
    rd = d_rdata;
    @(negedge clk);
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_miss;
    bit          exp_wb;
    logic [31:0] wb_addr;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[22];
    bit missed, tmo, stable;
    logic [31:0] rd;
    int pre, n, ntx, e_hit, e_miss, e_wb;

    vecs[0]  = '{LD, 32'h0000_0040, 32'h0, 32'h5A5A_0040, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{LD, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{ST, 32'h0000_0000, 32'h11, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{LD, 32'h0000_0000, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{LD, 32'h0000_0200, 32'h0, 32'h5A5A_0200, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{LD, 32'h0000_0400, 32'h0, 32'h5A5A_0400, 1'b1, 1'b1, 32'h0000_0000};
    vecs[6]  = '{LD, 32'h0000_0200, 32'h0, 32'h5A5A_0200, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{LD, 32'h0000_0000, 32'h0, 32'h0000_0011, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{LD, 32'h0000_0200, 32'h0, 32'h5A5A_0200, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{LD, 32'h0000_0000, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{LD, 32'h0000_0400, 32'h0, 32'h5A5A_0400, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{LD, 32'h0000_0000, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{LD, 32'h0000_0200, 32'h0, 32'h5A5A_0200, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{ST, 32'h0000_020C, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{LD, 32'h0000_020C, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{LD, 32'h0000_0208, 32'h0, 32'h5A5A_0208, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{LD, 32'h0000_07FC, 32'h0, 32'h5A5A_07FC, 1'b1, 1'b0, 32'h0};
    vecs[17] = '{LD, 32'hFFFF_FFE0, 32'h0, 32'hA5A5_FFE0, 1'b1, 1'b0, 32'h0};
    vecs[18] = '{LD, 32'h0000_0400, 32'h0, 32'h5A5A_0400, 1'b1, 1'b0, 32'h0};
    vecs[19] = '{LD, 32'h0000_0600, 32'h0, 32'h5A5A_0600, 1'b1, 1'b1, 32'h0000_0200};
    vecs[20] = '{LD, 32'h0000_020C, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    vecs[21] = '{LD, 32'h0000_0600, 32'h0, 32'h5A5A_0600, 1'b0, 1'b0, 32'h0};

    p_addr = '0; p_wdata = '0; p_rd = 1'b0; p_wr = 1'b0;
    d_addr = '0; d_wdata = '0; d_rd = 1'b0; d_wr = 1'b0;
    rst_n = 1'b0;

    // Reset state.
    #2;
    chk("rst_mem_enable", 32'(m_en), 32'd0);
    chk("rst_mem_write", 32'(m_wr), 32'd0);
    chk("rst_stall", 32'(p_stall), 32'd0);
    chk("rst_rdata", p_rdata, 32'd0);
    chk("rst_dm_enable", 32'(dm_en), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
`ifdef DCACHE_PERF_CNT_EN
    chk("perf_hit_reset", perf_hit, 32'd0);
    chk("perf_miss_reset", perf_miss, 32'd0);
    chk("perf_wb_reset", perf_wb, 32'd0);
`endif
    @(negedge clk);

    // A stray ack in IDLE must not start anything.
    #1 poke_req++;
    @(negedge clk); @(negedge clk); #1;
    chk("stray_ack_enable", 32'(m_en), 32'd0);
    chk("stray_ack_stall", 32'(p_stall), 32'd0);
    @(negedge clk);

    // Table-driven accesses on the default geometry.
    e_hit = 0; e_miss = 0; e_wb = 0;
    for (int i = 0; i < 22; i++) begin
      pre = log_addr.size();
      do_access(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, missed, rd, tmo);
      n = log_addr.size() - pre;
      ntx = vecs[i].exp_miss ? (vecs[i].exp_wb ? 2 : 1) : 0;
      e_hit += vecs[i].exp_miss ? 0 : 1;
      e_miss += vecs[i].exp_miss ? 1 : 0;
      e_wb += vecs[i].exp_wb ? 1 : 0;
      chk($sformatf("v%0d_timeout", i), 32'(tmo), 32'd0);
      chk($sformatf("v%0d_miss", i), 32'(missed), 32'(vecs[i].exp_miss));
      if (vecs[i].cmd == LD) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_mem_txns", i), 32'(n), 32'(ntx));
      if (vecs[i].exp_miss && n == ntx) begin
        if (vecs[i].exp_wb) begin
          chk($sformatf("v%0d_wb_write", i), 32'(log_wr[pre]), 32'd1);
          chk($sformatf("v%0d_wb_addr", i), log_addr[pre], vecs[i].wb_addr);
        end
        chk($sformatf("v%0d_refill_write", i), 32'(log_wr[pre+ntx-1]), 32'd0);
        chk($sformatf("v%0d_refill_addr", i), log_addr[pre+ntx-1], vecs[i].addr & 32'hFFFF_FFE0);
      end
    end
`ifdef DCACHE_PERF_CNT_EN
    chk("perf_hit", perf_hit, 32'(e_hit));
    chk("perf_miss", perf_miss, 32'(e_miss));
    chk("perf_wb", perf_wb, 32'(e_wb));
`endif

    // Slow memory: request must hold steady and nothing installs early.
    lat = 10;
    p_addr = 32'h0000_0860; p_rd = 1'b1;
    #1;
    chk("slow_first_stall", 32'(p_stall), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!(m_en === 1'b1 && m_wr === 1'b0 && m_addr === 32'h0000_0860 && p_stall === 1'b1))
        stable = 1'b0;
    end
    chk("slow_req_stable", 32'(stable), 32'd1);
    for (int i = 0; i < 50 && p_stall; i++) begin
      @(negedge clk); #1;
    end
    chk("slow_done", 32'(p_stall), 32'd0);
    chk("slow_rdata", p_rdata, 32'h5A5A_0860);
    @(negedge clk);
    p_rd = 1'b0;

    // Reset asserted in the middle of a refill.
    lat = 20;
    p_addr = 32'h0000_0C60; p_rd = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    chk("midrst_pre_enable", 32'(m_en), 32'd1);
    chk("midrst_pre_addr", m_addr, 32'h0000_0C60);
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", 32'(m_en), 32'd0);
    chk("midrst_write", 32'(m_wr), 32'd0);
    p_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    @(negedge clk);
    do_access(LD, 32'h0000_0C60, 32'h0, missed, rd, tmo);
    chk("postrst_c60_miss", 32'(missed), 32'd1);
    chk("postrst_c60_rdata", rd, 32'h5A5A_0C60);
    do_access(LD, 32'h0000_0860, 32'h0, missed, rd, tmo);
    chk("postrst_860_miss", 32'(missed), 32'd1);
    chk("postrst_860_timeout", 32'(tmo), 32'd0);

    // Direct-mapped build: 0x000 and 0x400 share set 0.
    dm_access(LD, 32'h0000_0000, 32'h0, missed, rd, tmo);
    chk("dm_0_miss", 32'(missed), 32'd1);
    chk("dm_0_rdata", rd, 32'h5A5A_0000);
    dm_access(LD, 32'h0000_0400, 32'h0, missed, rd, tmo);
    chk("dm_400_miss", 32'(missed), 32'd1);
    chk("dm_400_rdata", rd, 32'h5A5A_0400);
    chk("dm_clean_no_wb", 32'(dm_nwr), 32'd0);
    dm_access(LD, 32'h0000_0000, 32'h0, missed, rd, tmo);
    chk("dm_conflict_miss", 32'(missed), 32'd1);
    dm_access(ST, 32'h0000_0004, 32'h77, missed, rd, tmo);
    chk("dm_store_hit", 32'(missed), 32'd0);
    dm_access(LD, 32'h0000_0004, 32'h0, missed, rd, tmo);
    chk("dm_store_readback", rd, 32'h0000_0077);
    dm_access(LD, 32'h0000_0400, 32'h0, missed, rd, tmo);
    chk("dm_dirty_miss", 32'(missed), 32'd1);
    chk("dm_dirty_wb", 32'(dm_nwr), 32'd1);
    chk("dm_refills", 32'(dm_nrd), 32'd4);
    chk("dm_timeout", 32'(tmo), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised, N-way set-associative, write-back, write-allocate L1 data cache.
- Sits between the CPU MEM stage (single-word load/store port with stall) and data memory (full-line port with enable/write/ack handshake).
- Replaces the single-way, fixed-geometry data cache. Adds configurable associativity, set count and line size, plus true-LRU replacement.

Parameters:
- ADDR_W, 32: address and core data width in bits.
- LINE_BYTES, 32: bytes per line; power of two, ≥8. Memory data width = 8*LINE_BYTES.
- SETS, 16: number of sets; power of two, ≥2.
- WAYS, 2: associativity; power of two, 1..8.
- Derived:
  - OFF_W = log2(LINE_BYTES)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W-IDX_W-OFF_W
  - LRU_W = max(1, log2(WAYS))

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored (word access).
- p1_data_i  in  ADDR_W  store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; never asserted together with MemRead.
- p1_data_o  out  ADDR_W  load data.
- p1_stall_o  out  1  request not complete this cycle.
- mem_addr_o  out  ADDR_W  line address, low OFF_W bits zero.
- mem_data_o  out  8*LINE_BYTES  write-back line.
- mem_data_i  in  8*LINE_BYTES  refill line.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - tag = addr[ADDR_W-1 : IDX_W+OFF_W]
  - index = addr[IDX_W+OFF_W-1 : OFF_W]
  - word = addr[OFF_W-1 : 2]
- Per way and set: valid bit, dirty bit, tag, line. Per set, per way: LRU_W-bit age (0 = MRU).
- Reset (async, rst_i=0): state=IDLE; all valid/dirty cleared; ages initialised to way number. Outputs mem_enable_o=0, mem_write_o=0, p1_stall_o=0 when no request, p1_data_o=0 when no request.
- Hit: request present and some valid way's tag matches. Resolved combinationally in the same cycle; p1_stall_o=0.
  - Load: p1_data_o = selected word of the hit way.
  - Store: the word is written into the hit way at the clock edge and the dirty bit is set.
  - Every hit updates LRU: the hit way's age goes to 0; ways younger than its old age increment.
- Miss: p1_stall_o=1 combinationally. The core holds address, data and command stable until stall drops.
- Victim selection: the lowest-numbered invalid way; otherwise the way with age WAYS-1. Latched in IDLE on the miss edge.
- FSM states: IDLE, WRITEBACK, REFILL, FILLDONE.
  - IDLE→WRITEBACK: miss and victim valid and dirty. Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o=victim line.
  - IDLE→REFILL: miss and victim clean/invalid. Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={p1 tag, index, 0}.
  - WRITEBACK→REFILL: on mem_ack_i. mem_enable_o stays 1; mem_write_o drops to 0 in the next cycle.
  - REFILL→FILLDONE: on mem_ack_i. mem_data_i is written into the victim way (valid=1, dirty=0, tag=p1 tag); mem_enable_o drops to 0.
  - FILLDONE→IDLE: unconditional. The request now hits. A store completes in this cycle and sets dirty.
- Handshake:
  - mem_enable_o, mem_write_o and mem_addr_o are registered and stable while waiting for ack.
  - mem_ack_i outside WRITEBACK/REFILL is ignored.
- Minimum miss penalty: clean miss 3 cycles + memory latency; dirty miss 4 cycles + 2×latency.
- Request withdrawn mid-miss: the FSM still completes the transaction, and the refilled line is installed.
- WAYS=1: behaves as a direct-mapped cache; LRU storage unused.
- Reset mid-miss: FSM returns to IDLE immediately. Cached dirty data is discarded; memory may see a truncated request.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined, adds output ports perf_hit_o[31:0], perf_miss_o[31:0] and perf_wb_o[31:0]:
  - perf_hit_o increments once per request completed without entering the miss FSM.
  - perf_miss_o increments on each IDLE→WRITEBACK/REFILL transition.
  - perf_wb_o increments on each WRITEBACK ack.
  - All three wrap at 2^32 and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then load 0x0000_0040 → stall; mem request addr 0x40, write=0. Ack with line word1=0xDEADBEEF, load 0x44 returns 0xDEADBEEF, stall low from FILLDONE.
- Default geometry: store 0x11 to 0x000, then load 0x200 and 0x400 (same set 0) → the 0x400 miss evicts the dirty 0x000 line. A write-back to addr 0x000 precedes the refill of 0x400.
- 2-way LRU: load 0x000, 0x200, re-load 0x000, then load 0x400 → victim is 0x200's way; 0x000 still hits with no stall.
- WAYS=1, SETS=32 build: loads 0x000 then 0x400 conflict → second access misses; clean victim, so no write-back issued.
- Memory ack delayed 10 cycles → mem_enable_o/mem_addr_o remain stable all 10 cycles, and no early install occurs. Then assert rst_i low mid-refill → mem_enable_o=0 immediately, and a subsequent load of the same address misses.
- DCACHE_PERF_CNT_EN build: 3 hits, 2 misses, 1 dirty eviction → perf_hit_o=3, perf_miss_o=2, perf_wb_o=1.
